// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding slice: operand-select encodings
// and register-file addressing defaults.
package hazard_forward_unit_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int X0             = 0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_MDU   = 2'b11;

endpackage

// File: rtl/hazard_forward_unit_mdu_scoreboard.sv
// Fixed-latency MDU tracker: counts down from issue to writeback and holds the
// pending destination. Status flags are registered from the next-count value.
module mdu_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [REG_AW-1:0] start_rd,
  input  logic              kill,
  output logic              busy,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              pend
);

  localparam int            CW    = $clog2(MDU_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MDU_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_next_s;
  logic              accept_s;
  logic              busy_r;
  logic              wb_valid_r;
  logic              pend_r;
  logic [REG_AW-1:0] wb_rd_r;

  assign accept_s = start && (cnt_r == ZERO_C) && !kill;

  // Next count: kill wins over a simultaneous issue.
  always_comb begin
    cnt_next_s = cnt_r;
    if (kill) begin
      cnt_next_s = ZERO_C;
    end else if (accept_s) begin
      cnt_next_s = LAT_C;
    end else if (cnt_r != ZERO_C) begin
      cnt_next_s = cnt_r - ONE_C;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter, pending destination and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= ZERO_C;
      busy_r     <= 1'b0;
      wb_valid_r <= 1'b0;
      pend_r     <= 1'b0;
      wb_rd_r    <= '0;
    end else begin
      cnt_r      <= cnt_next_s;
      busy_r     <= (cnt_next_s != ZERO_C);
      wb_valid_r <= (cnt_next_s == ONE_C);
      pend_r     <= (cnt_next_s > ONE_C);
      if (accept_s) begin
        wb_rd_r <= start_rd;
      end else begin
        wb_rd_r <= wb_rd_r;
      end
    end
  end

  assign busy     = busy_r;
  assign wb_valid = wb_valid_r;
  assign pend     = pend_r;
  assign wb_rd    = wb_rd_r;

endmodule

// File: rtl/hazard_forward_unit.sv
// ID/EX hazard unit: per-source operand forwarding, load-use / MDU stall
// generation and a saturating stall-cycle counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int NUM_SRC = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]        if_id_rs_used,
  input  logic [REG_AW-1:0]         if_id_rd,
  input  logic                      if_id_regwrite,
  input  logic                      if_id_mdu,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memread,
  input  logic                      id_ex_mdu_start,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  input  logic                      mdu_kill,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      id_ex_bubble,
  output logic                      mdu_busy,
  output logic                      mdu_wb_valid,
  output logic [REG_AW-1:0]         mdu_wb_rd,
  output logic [CNT_W-1:0]          stall_count
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(X0);

  logic               mdu_pend_s;
  logic               ex_mem_ok_s;
  logic               mem_wb_ok_s;
  logic               mdu_fwd_ok_s;
  logic               load_ok_s;
  logic               mdu_raw_ok_s;
  logic               waw_s;
  logic               struct_s;
  logic               stall_s;
  logic [NUM_SRC-1:0] load_hit_s;
  logic [NUM_SRC-1:0] raw_hit_s;
  logic [CNT_W-1:0]   stall_count_r;

  mdu_scoreboard #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_mdu_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .start    (id_ex_mdu_start),
    .start_rd (id_ex_rd),
    .kill     (mdu_kill),
    .busy     (mdu_busy),
    .wb_valid (mdu_wb_valid),
    .wb_rd    (mdu_wb_rd),
    .pend     (mdu_pend_s)
  );

  // Producers that may forward or hazard; x0 is never a real destination.
  assign ex_mem_ok_s  = ex_mem_regwrite && (ex_mem_rd != ZERO_REG);
  assign mem_wb_ok_s  = mem_wb_regwrite && (mem_wb_rd != ZERO_REG);
  assign mdu_fwd_ok_s = mdu_wb_valid && (mdu_wb_rd != ZERO_REG);
  assign load_ok_s    = id_ex_memread && (id_ex_rd != ZERO_REG);
  assign mdu_raw_ok_s = mdu_busy && mdu_pend_s && (mdu_wb_rd != ZERO_REG);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] ex_rs_s;
    logic [REG_AW-1:0] id_rs_s;
    logic [1:0]        sel_s;

    assign ex_rs_s = id_ex_rs[i*REG_AW +: REG_AW];
    assign id_rs_s = if_id_rs[i*REG_AW +: REG_AW];

    // Youngest producer wins: EX/MEM, then MEM/WB, then the MDU port.
    always_comb begin
      sel_s = FWD_RF;
      if (ex_mem_ok_s && (ex_mem_rd == ex_rs_s)) begin
        sel_s = FWD_EXMEM;
      end else if (mem_wb_ok_s && (mem_wb_rd == ex_rs_s)) begin
        sel_s = FWD_MEMWB;
      end else if (mdu_fwd_ok_s && (mdu_wb_rd == ex_rs_s)) begin
        sel_s = FWD_MDU;
      end else begin
        sel_s = FWD_RF;
      end
    end

    assign fwd_sel[2*i +: 2] = sel_s;
    assign load_hit_s[i] = if_id_rs_used[i] && load_ok_s && (id_ex_rd == id_rs_s);
    assign raw_hit_s[i]  = if_id_rs_used[i] && mdu_raw_ok_s && (mdu_wb_rd == id_rs_s);
  end

  // On the writeback cycle itself the MDU result is forwarded, so only cnt>1 blocks.
  assign waw_s    = mdu_busy && mdu_pend_s && if_id_regwrite &&
                    (if_id_rd == mdu_wb_rd) && (mdu_wb_rd != ZERO_REG);
  assign struct_s = if_id_mdu && ((mdu_busy && mdu_pend_s) || id_ex_mdu_start);
  assign stall_s  = (|load_hit_s) || (|raw_hit_s) || waw_s || struct_s;

  assign stall        = stall_s;
  assign id_ex_bubble = stall_s;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_r <= '0;
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule
